// File: rtl/param_data_memory_if.sv
// Request/response bundle between the CPU load/store path and param_data_memory.
interface param_data_memory_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  read;
   logic                  write;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  busywait;

   modport master (
      output read, write, address, writedata,
      input  readdata, busywait
   );

   modport slave (
      input  read, write, address, writedata,
      output readdata, busywait
   );
endinterface

// File: rtl/param_data_memory.sv
// Single-port data memory with LATENCY-cycle access and busywait stall; operands latched at acceptance.
// Optional macro DMEM_RESET_CLEAR_EN: reset also clears every memory word.
module param_data_memory #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 5
) (
   input logic                clock,
   input logic                reset,
   param_data_memory_if.slave bus
);
   localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
   localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  op_wr_q, op_wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  busy;
   logic                  mem_we;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      busy    = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            // read and write together is a conflict and is ignored
            if (bus.read ^ bus.write) begin
               busy    = 1'b1;
               state_d = BUSY;
               cnt_d   = LAT_M1;
               op_wr_d = bus.write;
               addr_d  = bus.address;
               wdata_d = bus.writedata;
            end
         end
         BUSY: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               state_d = DONE;
               if (op_wr_q) mem_we = 1'b1;
               else         rdata_d = mem_q[addr_q];
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (reset) begin
         busy   = 1'b0;
         mem_we = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clock) begin
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

   always_ff @(posedge clock) begin
`ifdef DMEM_RESET_CLEAR_EN
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[addr_q] <= wdata_q;
      end
`else
      if (mem_we) mem_q[addr_q] <= wdata_q;
`endif
   end

   assign bus.busywait = busy;
   assign bus.readdata = rdata_q;
endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory (8x256, LATENCY=5): stimulus queues expected readdata per access,
// a monitor checks it when busywait falls.
module tb_param_data_memory;
   localparam int LAT = 5;

   typedef struct {
      string      name;
      logic [7:0] rd;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   param_data_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

   param_data_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LATENCY(LAT)) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Counts busywait-high cycles, including the acceptance cycle already in progress.
   task automatic wait_busy(input string nm, input bit mut_en, input logic [7:0] mut_a);
      int n = 1;
      forever begin
         @(negedge clk);
         if (!bus.busywait) break;
         n++;
         if (mut_en && n == 3) bus.address = mut_a;
         if (n > 60) break;
      end
      chk({"lat_", nm}, n, LAT + 1);
   endtask

   task automatic access(input string nm, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input bit mut_en, input logic [7:0] mut_a,
                         input bit hold);
      @(negedge clk);
      #1;
      bus.read      = !wr;
      bus.write     = wr;
      bus.address   = a;
      bus.writedata = d;
      sb.push_back('{nm, exp_rd});
      #1 chk({"rise_", nm}, bus.busywait, 1);
      wait_busy(nm, mut_en, mut_a);
      if (!hold) begin
         #1;
         bus.read  = 1'b0;
         bus.write = 1'b0;
      end
   endtask

   initial begin : monitor
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (prev && !bus.busywait && !reset) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk(e.name, bus.readdata, e.rd);
            end
         end
         prev = bus.busywait;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0] macro_exp;
      reset         = 1'b1;
      bus.read      = 1'b0;
      bus.write     = 1'b0;
      bus.address   = '0;
      bus.writedata = '0;
      repeat (2) @(negedge clk);
      chk("rst_busywait", bus.busywait, 0);
      chk("rst_readdata", bus.readdata, 8'h00);
      #1 reset = 1'b0;

      // write then read
      access("t1_wr", 1, 8'h03, 8'hA5, 8'h00, 0, 8'h00, 0);
      access("t1_rd", 0, 8'h03, 8'h00, 8'hA5, 0, 8'h00, 0);

      // address changed mid-access must not affect the read
      access("t2_wr", 1, 8'h10, 8'h11, 8'hA5, 0, 8'h00, 0);
      access("t2_rd", 0, 8'h10, 8'h00, 8'h11, 1, 8'h20, 0);

      // conflicting read+write is ignored
      access("t3_wr", 1, 8'h05, 8'h42, 8'h11, 0, 8'h00, 0);
      @(negedge clk);
      #1;
      bus.read      = 1'b1;
      bus.write     = 1'b1;
      bus.address   = 8'h05;
      bus.writedata = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_conf_busy", bus.busywait, 0);
         chk("t3_conf_rd", bus.readdata, 8'h11);
      end
      #1;
      bus.read  = 1'b0;
      bus.write = 1'b0;
      access("t3_rd", 0, 8'h05, 8'h00, 8'h42, 0, 8'h00, 0);

      // reset during the third BUSY cycle aborts the write
      access("t4_wr", 1, 8'h07, 8'h99, 8'h42, 0, 8'h00, 0);
      @(negedge clk);
      #1;
      bus.write     = 1'b1;
      bus.address   = 8'h07;
      bus.writedata = 8'h3C;
      repeat (3) @(negedge clk);
      chk("t4_busy_before_rst", bus.busywait, 1);
      #1;
      reset     = 1'b1;
      bus.write = 1'b0;
      @(negedge clk);
      chk("t4_rst_busy", bus.busywait, 0);
      chk("t4_rst_rd", bus.readdata, 8'h00);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("t4_idle_busy", bus.busywait, 0);
      access("t4_rd", 0, 8'h07, 8'h00, 8'h99, 0, 8'h00, 0);

      // back-to-back reads with the request held through DONE
      access("t5_rd1", 0, 8'h03, 8'h00, 8'hA5, 0, 8'h00, 1);
      #1 bus.address = 8'h10;
      sb.push_back('{"t5_rd2", 8'h11});
      @(negedge clk);
      chk("t5_bubble", bus.busywait, 1);
      wait_busy("t5_rd2", 0, 8'h00);
      #1 bus.read = 1'b0;

      // memory persistence across reset depends on the clear macro
      access("t6_wr", 1, 8'hFF, 8'h5A, 8'h11, 0, 8'h00, 0);
      @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
`ifdef DMEM_RESET_CLEAR_EN
      macro_exp = 8'h00;
`else
      macro_exp = 8'h5A;
`endif
      access("t6_rd", 0, 8'hFF, 8'h00, macro_exp, 0, 8'h00, 0);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
